// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Sums NSAMP upstream adder results per frame and presents the total
//            with a valid/ready handshake. Define SUM_ACCUMULATOR_SATURATE_EN
//            to clamp the accumulator on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int WIDTH     = 8,
  parameter int NSAMP     = 4,
  parameter int ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic [7:0]           sample_cnt,
  output logic                 overflow,
  output logic                 enable_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] c_nsamp = 8'(NSAMP);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [7:0]           r_cnt;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_deliver;
  logic                 w_carry;
  logic                 w_last;
  logic [7:0]           w_cnt_inc;
  logic [ACC_WIDTH:0]   w_in_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_add;

  assign in_ready     = (r_state != HOLD);
  assign out_valid    = (r_state == HOLD);
  assign enable_pulse = out_valid & out_ready;
  assign out_total    = r_acc;
  assign sample_cnt   = r_cnt;
  assign overflow     = r_ovf;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = enable_pulse;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_last    = (w_cnt_inc == c_nsamp);

  // One extra bit on the adder exposes the carry out of ACC_WIDTH.
  always_comb begin
    w_in_ext          = '0;
    w_in_ext[WIDTH:0] = in_sum;
  end

  assign w_sum   = {1'b0, r_acc} + w_in_ext;
  assign w_carry = w_sum[ACC_WIDTH];

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further non-zero addend carries again, so the
  // accumulator stays at all ones for the rest of the frame.
  assign w_acc_add = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_add = w_sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        if (in_valid && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_deliver) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_acc <= w_in_ext[ACC_WIDTH-1:0];
        r_cnt <= 8'd1;
      end else begin
        r_acc <= w_acc_add;
        r_cnt <= w_cnt_inc;
        if (w_carry) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
